// File: rtl/rx_gate_sequencer_pkg.sv
// Shared types for the RX gate sequencer.
// FSM state encoding and default counter width.
package rx_gate_sequencer_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUAL     = 3'd1,
    DELAY    = 3'd2,
    ACQ      = 3'd3,
    WAIT_LOW = 3'd4
  } state_e;

endpackage

// File: rtl/rx_gate_sequencer_if.sv
// Gate/config/sample bundle for rx_gate_sequencer.
// master drives gate, config, strobe; slave returns window/status.
interface rx_gate_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             gate_sync;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] num_samples;
  logic             sample_strobe;
  logic             clear_flags;
  logic             window;
  logic             sample_valid;
  logic             sof;
  logic             eof;
  logic             busy;
  logic             missed_trig;
  logic [CNT_W-1:0] trig_count;

  modport master (
    output enable, gate_sync, delay,
    output num_samples, sample_strobe,
    output clear_flags,
    input  window, sample_valid, sof, eof,
    input  busy, missed_trig, trig_count
  );

  modport slave (
    input  enable, gate_sync, delay,
    input  num_samples, sample_strobe,
    input  clear_flags,
    output window, sample_valid, sof, eof,
    output busy, missed_trig, trig_count
  );
endinterface

// File: rtl/rx_gate_sequencer_edge.sv
// rising_edge_detect: registers the gate level once per clock.
// Ports: clock, reset_n, level in; rise out (level & ~level_d).
module rising_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic gate_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) gate_d <= 1'b0;
    else          gate_d <= level;
  end

  assign rise = level & ~gate_d;

endmodule

// File: rtl/rx_gate_sequencer.sv
// Gate-triggered acquisition window sequencer (qualify, delay, acquire).
// Ports: clock, reset_n, bus (slave: gate/config/strobe in, window/status out).
module rx_gate_sequencer
  import rx_gate_sequencer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_HIGH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  rx_gate_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MH  = CNT_W'(MIN_HIGH);

  state_e           state_q, state_d;
  logic             rise;
  logic             accept;
  logic [CNT_W-1:0] qual_q;
  logic [CNT_W-1:0] dly_q;
  logic [CNT_W-1:0] smp_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] trig_q;
  logic             window_q;
  logic             busy_q;
  logic             missed_q;
  logic             sv;
  logic             last;

  rising_edge_detect u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (bus.gate_sync),
    .rise    (rise)
  );

  assign sv   = window_q & bus.sample_strobe;
  assign last = (smp_q == n_q - ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (MIN_HIGH == 1) accept  = 1'b1;
          else               state_d = QUAL;
        end
      end
      QUAL: begin
        if (!bus.gate_sync)       state_d = IDLE;
        else if (qual_q + ONE == MH) accept = 1'b1;
      end
      DELAY: begin
        if (dly_q == ONE) state_d = ACQ;
      end
      ACQ: begin
        // gate falling here is ignored; only the last sample closes
        if (sv && last) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.gate_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      unique case (1'b1)
        (bus.num_samples == '0): state_d = WAIT_LOW;
        (bus.num_samples != '0 && bus.delay == '0):
          state_d = ACQ;
        default: state_d = DELAY;
      endcase
    end
    if (!bus.enable) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  // edge cycle counts as the first high cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                qual_q <= '0;
    else if (state_d != QUAL)    qual_q <= '0;
    else if (state_q == QUAL)    qual_q <= qual_q + ONE;
    else                         qual_q <= ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              dly_q <= '0;
    else if (!bus.enable)      dly_q <= '0;
    else if (accept)           dly_q <= bus.delay;
    else if (state_q == DELAY) dly_q <= dly_q - ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      smp_q <= '0;
      n_q   <= '0;
    end else begin
      if (accept) n_q <= bus.num_samples;
      if (state_q != ACQ || !bus.enable) smp_q <= '0;
      else if (sv)                       smp_q <= smp_q + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    trig_q <= '0;
    else if (accept) trig_q <= trig_q + ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      window_q <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      window_q <= (state_d == ACQ);
      busy_q   <= (state_d != IDLE);
      if (rise && (state_q == DELAY || state_q == ACQ))
        missed_q <= 1'b1;
      else if (bus.clear_flags)
        missed_q <= 1'b0;
    end
  end

  assign bus.window       = window_q;
  assign bus.busy         = busy_q;
  assign bus.missed_trig  = missed_q;
  assign bus.trig_count   = trig_q;
  assign bus.sample_valid = sv;
  assign bus.sof          = sv & (smp_q == '0);
  assign bus.eof          = sv & last;

endmodule

// File: tb/tb_rx_gate_sequencer.sv
// Directed bench for rx_gate_sequencer.
// DUT a: CNT_W=16, MIN_HIGH=2; DUT b: CNT_W=4, MIN_HIGH=1 for wrap.
module tb_rx_gate_sequencer;

  logic clock;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  rx_gate_sequencer_if #(.CNT_W(16)) bus_a ();
  rx_gate_sequencer_if #(.CNT_W(4))  bus_b ();

  rx_gate_sequencer #(.CNT_W(16), .MIN_HIGH(2)) u_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  rx_gate_sequencer #(.CNT_W(4), .MIN_HIGH(1)) u_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", bus_a.busy); end
    n_cmp++; if (bus_a.window !== 1'b0) begin n_bad++; $display("FAIL rst_window got=%b exp=0", bus_a.window); end
    n_cmp++; if (bus_a.missed_trig !== 1'b0) begin n_bad++; $display("FAIL rst_missed got=%b exp=0", bus_a.missed_trig); end
    n_cmp++; if (bus_a.trig_count !== 16'd0) begin n_bad++; $display("FAIL rst_trig got=%0d exp=0", bus_a.trig_count); end
    n_cmp++; if (bus_b.trig_count !== 4'd0) begin n_bad++; $display("FAIL rst_trig_b got=%0d exp=0", bus_b.trig_count); end
    tick;
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    bus_a.delay = 16'd5; bus_a.num_samples = 16'd4;
    bus_a.gate_sync = 1'b1;
    tick; #1;
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL basic_qual_busy got=%b exp=1", bus_a.busy); end
    n_cmp++; if (bus_a.trig_count !== 16'd0) begin n_bad++; $display("FAIL basic_qual_trig got=%0d exp=0", bus_a.trig_count); end
    tick; #1;
    n_cmp++; if (bus_a.trig_count !== 16'd1) begin n_bad++; $display("FAIL basic_trig got=%0d exp=1", bus_a.trig_count); end
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      n_cmp++; if (bus_a.window !== 1'b0) begin n_bad++; $display("FAIL basic_delay%0d got=%b exp=0", i, bus_a.window); end
    end
    for (int i = 0; i < 4; i++) begin
      tick; bus_a.sample_strobe = 1'b1;
      if (i == 1) begin bus_a.num_samples = 16'd9; bus_a.delay = 16'd1; end
      #1;
      n_cmp++; if (bus_a.sample_valid !== 1'b1) begin n_bad++; $display("FAIL basic_sv%0d got=%b exp=1", i, bus_a.sample_valid); end
      n_cmp++; if (bus_a.sof !== (i == 0)) begin n_bad++; $display("FAIL basic_sof%0d got=%b exp=%b", i, bus_a.sof, (i == 0)); end
      n_cmp++; if (bus_a.eof !== (i == 3)) begin n_bad++; $display("FAIL basic_eof%0d got=%b exp=%b", i, bus_a.eof, (i == 3)); end
      tick; bus_a.sample_strobe = 1'b0; #1;
      n_cmp++; if (bus_a.window !== (i != 3)) begin n_bad++; $display("FAIL basic_win%0d got=%b exp=%b", i, bus_a.window, (i != 3)); end
    end
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL basic_waitlow got=%b exp=1", bus_a.busy); end
    bus_a.gate_sync = 1'b0;
    tick; #1;
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle got=%b exp=0", bus_a.busy); end
  endtask

  task automatic test_glitch;
    bus_a.gate_sync = 1'b1;
    tick; #1;
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL glitch_qual got=%b exp=1", bus_a.busy); end
    bus_a.gate_sync = 1'b0;
    tick; #1;
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle got=%b exp=0", bus_a.busy); end
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      n_cmp++; if (bus_a.window !== 1'b0) begin n_bad++; $display("FAIL glitch_win%0d got=%b exp=0", i, bus_a.window); end
    end
    n_cmp++; if (bus_a.trig_count !== 16'd1) begin n_bad++; $display("FAIL glitch_trig got=%0d exp=1", bus_a.trig_count); end
  endtask

  task automatic test_corners;
    bus_a.delay = 16'd0; bus_a.num_samples = 16'd1;
    bus_a.gate_sync = 1'b1;
    tick; tick; #1;
    n_cmp++; if (bus_a.window !== 1'b1) begin n_bad++; $display("FAIL d0_window got=%b exp=1", bus_a.window); end
    n_cmp++; if (bus_a.trig_count !== 16'd2) begin n_bad++; $display("FAIL d0_trig got=%0d exp=2", bus_a.trig_count); end
    bus_a.sample_strobe = 1'b1; #1;
    n_cmp++; if ({bus_a.sof, bus_a.eof} !== 2'b11) begin n_bad++; $display("FAIL n1_sofeof got=%b exp=11", {bus_a.sof, bus_a.eof}); end
    tick; bus_a.sample_strobe = 1'b0; #1;
    n_cmp++; if (bus_a.window !== 1'b0) begin n_bad++; $display("FAIL n1_close got=%b exp=0", bus_a.window); end
    bus_a.gate_sync = 1'b0;
    tick;
    bus_a.num_samples = 16'd0; bus_a.delay = 16'd3;
    bus_a.gate_sync = 1'b1;
    tick; tick; #1;
    n_cmp++; if (bus_a.trig_count !== 16'd3) begin n_bad++; $display("FAIL n0_trig got=%0d exp=3", bus_a.trig_count); end
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL n0_busy got=%b exp=1", bus_a.busy); end
    for (int i = 0; i < 5; i++) begin
      bus_a.sample_strobe = 1'b1;
      tick; #1;
      n_cmp++; if ({bus_a.window, bus_a.sof, bus_a.eof} !== 3'b000) begin n_bad++; $display("FAIL n0_nowin%0d got=%b exp=000", i, {bus_a.window, bus_a.sof, bus_a.eof}); end
    end
    bus_a.sample_strobe = 1'b0;
    bus_a.gate_sync = 1'b0;
    tick; #1;
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL n0_idle got=%b exp=0", bus_a.busy); end
  endtask

  task automatic test_missed;
    bus_a.delay = 16'd2; bus_a.num_samples = 16'd2;
    bus_a.gate_sync = 1'b1;
    tick; tick; tick; #1;
    n_cmp++; if (bus_a.window !== 1'b0) begin n_bad++; $display("FAIL miss_dly got=%b exp=0", bus_a.window); end
    tick; #1;
    n_cmp++; if (bus_a.window !== 1'b1) begin n_bad++; $display("FAIL miss_open got=%b exp=1", bus_a.window); end
    bus_a.gate_sync = 1'b0;
    tick; bus_a.gate_sync = 1'b1;
    tick; #1;
    n_cmp++; if (bus_a.missed_trig !== 1'b1) begin n_bad++; $display("FAIL miss_set got=%b exp=1", bus_a.missed_trig); end
    n_cmp++; if (bus_a.window !== 1'b1) begin n_bad++; $display("FAIL miss_keepwin got=%b exp=1", bus_a.window); end
    n_cmp++; if (bus_a.trig_count !== 16'd4) begin n_bad++; $display("FAIL miss_trig got=%0d exp=4", bus_a.trig_count); end
    bus_a.sample_strobe = 1'b1;
    tick; #1;
    n_cmp++; if (bus_a.eof !== 1'b1) begin n_bad++; $display("FAIL miss_eof got=%b exp=1", bus_a.eof); end
    tick; bus_a.sample_strobe = 1'b0; #1;
    n_cmp++; if ({bus_a.window, bus_a.missed_trig} !== 2'b01) begin n_bad++; $display("FAIL miss_hold got=%b exp=01", {bus_a.window, bus_a.missed_trig}); end
    bus_a.clear_flags = 1'b1;
    tick; bus_a.clear_flags = 1'b0; #1;
    n_cmp++; if (bus_a.missed_trig !== 1'b0) begin n_bad++; $display("FAIL miss_clear got=%b exp=0", bus_a.missed_trig); end
    bus_a.gate_sync = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    bus_a.delay = 16'd0; bus_a.num_samples = 16'd4;
    bus_a.gate_sync = 1'b1;
    tick; tick; #1;
    n_cmp++; if (bus_a.window !== 1'b1) begin n_bad++; $display("FAIL abort_open got=%b exp=1", bus_a.window); end
    bus_a.sample_strobe = 1'b1;
    tick; bus_a.sample_strobe = 1'b0; bus_a.enable = 1'b0;
    tick; #1;
    n_cmp++; if ({bus_a.window, bus_a.busy} !== 2'b00) begin n_bad++; $display("FAIL abort_drop got=%b exp=00", {bus_a.window, bus_a.busy}); end
    n_cmp++; if (bus_a.trig_count !== 16'd5) begin n_bad++; $display("FAIL abort_trig got=%0d exp=5", bus_a.trig_count); end
    bus_a.enable = 1'b1; bus_a.gate_sync = 1'b0;
    tick; bus_a.gate_sync = 1'b1;
    tick; tick; #1;
    n_cmp++; if (bus_a.trig_count !== 16'd6) begin n_bad++; $display("FAIL abort_retrig got=%0d exp=6", bus_a.trig_count); end
    for (int i = 0; i < 4; i++) begin
      bus_a.sample_strobe = 1'b1; #1;
      n_cmp++; if ({bus_a.sof, bus_a.eof} !== {(i == 0), (i == 3)}) begin n_bad++; $display("FAIL abort_smp%0d got=%b exp=%b", i, {bus_a.sof, bus_a.eof}, {(i == 0), (i == 3)}); end
      tick;
    end
    bus_a.sample_strobe = 1'b0; #1;
    n_cmp++; if (bus_a.window !== 1'b0) begin n_bad++; $display("FAIL abort_close got=%b exp=0", bus_a.window); end
    bus_a.gate_sync = 1'b0;
    tick;
  endtask

  task automatic test_wrap;
    logic [3:0] exp;
    bus_b.delay = 4'd0; bus_b.num_samples = 4'd0;
    for (int i = 0; i < 16; i++) begin
      exp = 4'(i + 1);
      bus_b.gate_sync = 1'b1;
      tick; #1;
      n_cmp++; if (bus_b.trig_count !== exp) begin n_bad++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, bus_b.trig_count, exp); end
      n_cmp++; if ({bus_b.busy, bus_b.window} !== 2'b10) begin n_bad++; $display("FAIL wrap_state%0d got=%b exp=10", i, {bus_b.busy, bus_b.window}); end
      bus_b.gate_sync = 1'b0;
      tick;
    end
  endtask

  task automatic test_async_reset;
    bus_a.delay = 16'd10; bus_a.num_samples = 16'd2;
    bus_a.gate_sync = 1'b1;
    tick; tick; #1;
    n_cmp++; if (bus_a.trig_count !== 16'd7) begin n_bad++; $display("FAIL ar_trig got=%0d exp=7", bus_a.trig_count); end
    bus_a.gate_sync = 1'b0;
    tick; bus_a.gate_sync = 1'b1;
    tick; #1;
    n_cmp++; if (bus_a.missed_trig !== 1'b1) begin n_bad++; $display("FAIL ar_miss_dly got=%b exp=1", bus_a.missed_trig); end
    bus_a.gate_sync = 1'b0;
    tick; bus_a.gate_sync = 1'b1; bus_a.clear_flags = 1'b1;
    tick; bus_a.clear_flags = 1'b0; #1;
    n_cmp++; if (bus_a.missed_trig !== 1'b1) begin n_bad++; $display("FAIL ar_setwins got=%b exp=1", bus_a.missed_trig); end
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL ar_inDelay got=%b exp=1", bus_a.busy); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus_a.busy, bus_a.window, bus_a.missed_trig} !== 3'b000) begin n_bad++; $display("FAIL ar_flags got=%b exp=000", {bus_a.busy, bus_a.window, bus_a.missed_trig}); end
    n_cmp++; if (bus_a.trig_count !== 16'd0) begin n_bad++; $display("FAIL ar_count got=%0d exp=0", bus_a.trig_count); end
    bus_a.gate_sync = 1'b0;
    tick; reset_n = 1'b1;
    tick; #1;
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL ar_after got=%b exp=0", bus_a.busy); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus_a.enable = 1'b1; bus_a.gate_sync = 1'b0;
    bus_a.delay = '0; bus_a.num_samples = '0;
    bus_a.sample_strobe = 1'b0; bus_a.clear_flags = 1'b0;
    bus_b.enable = 1'b1; bus_b.gate_sync = 1'b0;
    bus_b.delay = '0; bus_b.num_samples = '0;
    bus_b.sample_strobe = 1'b0; bus_b.clear_flags = 1'b0;
    test_reset;
    test_basic;
    test_glitch;
    test_corners;
    test_missed;
    test_abort;
    test_wrap;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
